seq_divider: RTL

//   Self-contained iterative restoring divider: WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.

---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider_cond_negate.sv | 10 +
 rtl/seq_divider.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// Holds the FSM state encoding, counter sizing and the slot map of the conditional negators.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // One extra bit so the counter can represent WIDTH itself without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int NEG_OPA   = 0;
    localparam int NEG_OPB   = 1;
    localparam int NEG_QUO   = 2;
    localparam int NEG_REM   = 3;
    localparam int NEG_COUNT = 4;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bus between the issuing controller (master) and the divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             ovf;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, dbz, ovf
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, dbz, ovf
    );
endinterface

// File: rtl/seq_divider_cond_negate.sv
// Two's-complement conditional negation: out = neg ? -in : in.
module seq_divider_cond_negate #(
    parameter int N = 6
) (
    input  logic [N-1:0] in_i,
    input  logic         neg_i,
    output logic [N-1:0] out_o
);
    assign out_o = neg_i ? (~in_i + N'(1)) : in_i;
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, with signed mode,
// divide-by-zero and signed-overflow flags and results held between operations.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic             ovf_q;

    logic [WIDTH-1:0] neg_in  [NEG_COUNT];
    logic [WIDTH-1:0] neg_out [NEG_COUNT];
    logic             neg_sel [NEG_COUNT];

    logic [WIDTH:0]   shift_p;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] q_d;
    logic             dbz_hit;
    logic             ovf_hit;

    // Operand magnitudes on the way in, sign restoration on the way out.
    assign neg_in[NEG_OPA]  = bus.dividend;
    assign neg_sel[NEG_OPA] = bus.signed_op & bus.dividend[WIDTH-1];
    assign neg_in[NEG_OPB]  = bus.divisor;
    assign neg_sel[NEG_OPB] = bus.signed_op & bus.divisor[WIDTH-1];
    assign neg_in[NEG_QUO]  = q_q;
    assign neg_sel[NEG_QUO] = qneg_q;
    assign neg_in[NEG_REM]  = p_q;
    assign neg_sel[NEG_REM] = rneg_q;

    generate
        for (genvar gi = 0; gi < NEG_COUNT; gi++) begin : g_neg
            seq_divider_cond_negate #(.N(WIDTH)) u_neg (
                .in_i  (neg_in[gi]),
                .neg_i (neg_sel[gi]),
                .out_o (neg_out[gi])
            );
        end
    endgenerate

    // A negative trial difference means the divisor did not fit: restore P.
    assign shift_p = {p_q, q_q[WIDTH-1]};
    assign trial   = shift_p - {1'b0, d_q};
    assign p_d     = trial[WIDTH] ? shift_p[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};

    assign dbz_hit = (bus.divisor == '0);
    assign ovf_hit = bus.signed_op && (bus.dividend == MOST_NEG) && (bus.divisor == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            dividend_q  <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        p_q        <= '0;
                        q_q        <= neg_out[NEG_OPA];
                        d_q        <= neg_out[NEG_OPB];
                        dividend_q <= bus.dividend;
                        qneg_q     <= neg_sel[NEG_OPA] ^ neg_sel[NEG_OPB];
                        rneg_q     <= neg_sel[NEG_OPA];
                        dbz_q      <= dbz_hit;
                        ovf_q      <= ovf_hit;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= dbz_hit ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (dbz_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend_q;
                    end else begin
                        quotient_q  <= neg_out[NEG_QUO];
                        remainder_q <= neg_out[NEG_REM];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;

endmodule
